// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: decodes instructions and data writes from an
// external writer into a 32-entry display RAM, cursor and display-control state.
module lcd_responder #(
    parameter int BUSY_CYC = 40,
    parameter int CLR_CYC  = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_d,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [4:0] cursor,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       busy,
    output logic       init_done,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic       wr_valid,
    output logic       err
);

    localparam int CW = $clog2(CLR_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // bus bit layout inside the synchronizer: [10]=rs [9]=rw [8]=e [7:0]=d
    logic [10:0]   sync1;
    logic [10:0]   sync2;
    logic          e_prev;
    logic          cap_rs;
    logic          cap_rw;
    logic [7:0]    cap_d;
    logic          detect;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [4:0]    fill, fill_nx;
    logic          id, id_nx;
    logic [4:0]    cursor_nx;
    logic          disp_nx, curon_nx, init_nx;
    logic          cmd_valid_nx, wr_valid_nx, err_nx;
    logic [7:0]    cmd_code_nx;
    logic          ram_we;
    logic [4:0]    ram_waddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram [32];

    // two-flop synchronizer, falling-edge history and field capture while E is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 11'd0;
            sync2  <= 11'd0;
            e_prev <= 1'b0;
            cap_rs <= 1'b0;
            cap_rw <= 1'b0;
            cap_d  <= 8'd0;
        end else begin
            sync1  <= {lcd_rs, lcd_rw, lcd_e, lcd_d};
            sync2  <= sync1;
            e_prev <= sync2[8];
            if (sync2[8]) begin
                cap_rs <= sync2[10];
                cap_rw <= sync2[9];
                cap_d  <= sync2[7:0];
            end
        end
    end

    assign detect = e_prev & ~sync2[8];

    // next-state, decode and next-output logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        fill_nx      = fill;
        id_nx        = id;
        cursor_nx    = cursor;
        disp_nx      = disp_on;
        curon_nx     = cursor_on;
        init_nx      = init_done;
        cmd_valid_nx = 1'b0;
        wr_valid_nx  = 1'b0;
        err_nx       = 1'b0;
        cmd_code_nx  = cmd_code;
        ram_we       = 1'b0;
        ram_waddr    = cursor;
        ram_wdata    = cap_d;
        case (state)
            IDLE: begin
                if (detect && cap_rw) begin
                    err_nx = 1'b1;
                end else if (detect && cap_rs) begin
                    ram_we      = 1'b1;
                    wr_valid_nx = 1'b1;
                    cursor_nx   = id ? cursor + 5'd1 : cursor - 5'd1;
                    state_nx    = WAIT;
                    cnt_nx      = CW'(BUSY_CYC - 1);
                end else if (detect) begin
                    cmd_valid_nx = 1'b1;
                    cmd_code_nx  = cap_d;
                    state_nx     = WAIT;
                    cnt_nx       = CW'(BUSY_CYC - 1);
                    casez (cap_d)
                        8'b1???????: begin
                            // only the two visible 16-character windows are addressable
                            if (cap_d[6:4] == 3'b000) begin
                                cursor_nx = {1'b0, cap_d[3:0]};
                            end else if (cap_d[6:4] == 3'b100) begin
                                cursor_nx = {1'b1, cap_d[3:0]};
                            end else begin
                                err_nx = 1'b1;
                            end
                        end
                        8'b01??????: begin
                        end
                        8'b001?????: init_nx = 1'b1;
                        8'b0001????: begin
                            if (!cap_d[3]) begin
                                cursor_nx = cap_d[2] ? cursor + 5'd1 : cursor - 5'd1;
                            end else begin
                                cursor_nx = cursor;
                            end
                        end
                        8'b00001???: begin
                            disp_nx  = cap_d[2];
                            curon_nx = cap_d[1];
                        end
                        8'b000001??: id_nx = cap_d[1];
                        8'b0000001?: cursor_nx = 5'd0;
                        8'b00000001: begin
                            cursor_nx = 5'd0;
                            id_nx     = 1'b1;
                            state_nx  = CLEAR;
                            fill_nx   = 5'd0;
                        end
                        default: begin
                        end
                    endcase
                end else begin
                    state_nx = IDLE;
                end
            end
            CLEAR: begin
                err_nx    = detect;
                ram_we    = 1'b1;
                ram_waddr = fill;
                ram_wdata = 8'h20;
                fill_nx   = fill + 5'd1;
                // the 32 fill cycles count toward the total clear busy time
                if (fill == 5'd31) begin
                    state_nx = WAIT;
                    cnt_nx   = CW'(CLR_CYC - 33);
                end else begin
                    state_nx = CLEAR;
                end
            end
            WAIT: begin
                err_nx = detect;
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fill      <= 5'd0;
            id        <= 1'b1;
            cursor    <= 5'd0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'd0;
            wr_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            fill      <= fill_nx;
            id        <= id_nx;
            cursor    <= cursor_nx;
            disp_on   <= disp_nx;
            cursor_on <= curon_nx;
            init_done <= init_nx;
            busy      <= (state_nx != IDLE);
            cmd_valid <= cmd_valid_nx;
            cmd_code  <= cmd_code_nx;
            wr_valid  <= wr_valid_nx;
            err       <= err_nx;
        end
    end

    // display RAM, reset to blanks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ram[i] <= 8'h20;
            end
        end else if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // registered read port; a same-cycle write is seen on the following read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= ram[rd_addr];
        end
    end

endmodule

// File: tb/tb_lcd_responder.sv
// Randomized scoreboard bench for lcd_responder against a behavioural LCD model.
module tb_lcd_responder;

    localparam int BUSY_CYC = 40;
    localparam int CLR_CYC  = 1600;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_d;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [4:0] cursor;
    logic       disp_on, cursor_on, busy, init_done;
    logic       cmd_valid, wr_valid, err;
    logic [7:0] cmd_code;

    lcd_responder #(.BUSY_CYC(BUSY_CYC), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_d(lcd_d), .rd_addr(rd_addr), .rd_data(rd_data), .cursor(cursor),
        .disp_on(disp_on), .cursor_on(cursor_on), .busy(busy), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .wr_valid(wr_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic       wv;
        logic       er;
        logic [7:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  run_len = 0;
    int  last_len = -1;

    // behavioural model of the visible LCD state
    int  m_ram [32];
    int  m_cursor, m_id, m_disp, m_curon, m_init;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_ram[i] = 32;
        m_cursor = 0; m_id = 1; m_disp = 0; m_curon = 0; m_init = 0;
    endtask

    // monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && (cmd_valid || wr_valid || err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {cmd_valid, wr_valid, err}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_flags", {cmd_valid, wr_valid, err}, {e.cv, e.wv, e.er});
                if (e.cv) chk("cmd_code", cmd_code, e.code);
            end
        end
    end

    // length of each contiguous busy interval
    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
        end else if (busy) begin
            run_len++;
        end else if (run_len > 0) begin
            last_len = run_len;
            run_len = 0;
        end
    end

    task automatic bus_pulse(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // predict the effect of one transaction, queue its pulse, then drive it
    task automatic issue(input logic rs, input logic rw, input logic [7:0] d,
                         input bit drop, output int exp_len);
        ev_t e;
        int  a;
        e.cv = 1'b0; e.wv = 1'b0; e.er = 1'b0; e.code = d;
        exp_len = 0;
        if (rw || drop) begin
            e.er = 1'b1;
        end else if (rs) begin
            m_ram[m_cursor] = d;
            m_cursor = m_id ? (m_cursor + 1) % 32 : (m_cursor + 31) % 32;
            e.wv = 1'b1;
            exp_len = BUSY_CYC;
        end else begin
            e.cv = 1'b1;
            exp_len = BUSY_CYC;
            if (d >= 8'h80) begin
                a = d - 128;
                if (a < 16) m_cursor = a;
                else if (a >= 64 && a < 80) m_cursor = 16 + a - 64;
                else e.er = 1'b1;
            end else if (d >= 8'h40) begin
            end else if (d >= 8'h20) begin
                m_init = 1;
            end else if (d >= 8'h10) begin
                if ((d & 8'h08) == 0) m_cursor = (d & 8'h04) ? (m_cursor + 1) % 32 : (m_cursor + 31) % 32;
            end else if (d >= 8'h08) begin
                m_disp = (d >> 2) & 1; m_curon = (d >> 1) & 1;
            end else if (d >= 8'h04) begin
                m_id = (d >> 1) & 1;
            end else if (d >= 8'h02) begin
                m_cursor = 0;
            end else if (d == 8'h01) begin
                for (int i = 0; i < 32; i++) m_ram[i] = 32;
                m_cursor = 0; m_id = 1;
                exp_len = CLR_CYC;
            end
        end
        exp_q.push_back(e);
        last_len = -1;
        bus_pulse(rs, rw, d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_timeout", busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state();
        chk("cursor", cursor, m_cursor);
        chk("disp_on", disp_on, m_disp);
        chk("cursor_on", cursor_on, m_curon);
        chk("init_done", init_done, m_init);
    endtask

    task automatic check_ram();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("ram_%0d", i), rd_data, m_ram[i]);
        end
    endtask

    task automatic do_cmd(input logic rs, input logic rw, input logic [7:0] d);
        int exp_len;
        issue(rs, rw, d, 1'b0, exp_len);
        if (exp_len == 0) chk("no_busy", busy, 0);
        wait_idle();
        if (exp_len > 0) chk("busy_len", last_len, exp_len);
        check_state();
    endtask

    initial begin
        int         el;
        logic       rs, rw;
        logic [7:0] d;

        rst = 1'b1; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0; lcd_d = 8'd0; rd_addr = 5'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cmd_code", cmd_code, 0);
        chk("rst_pulses", {cmd_valid, wr_valid, err}, 0);
        check_state();
        rst = 1'b0;

        // initialisation sequence
        do_cmd(1'b0, 1'b0, 8'h38);
        do_cmd(1'b0, 1'b0, 8'h0C);
        do_cmd(1'b0, 1'b0, 8'h06);
        do_cmd(1'b0, 1'b0, 8'h01);
        check_ram();

        // line-2 end wraps to line-1 start
        do_cmd(1'b0, 1'b0, 8'hCF);
        do_cmd(1'b1, 1'b0, 8'h41);
        do_cmd(1'b1, 1'b0, 8'h42);

        // decrementing entry mode wraps 0 -> 31
        do_cmd(1'b0, 1'b0, 8'h04);
        do_cmd(1'b0, 1'b0, 8'h80);
        do_cmd(1'b1, 1'b0, 8'h5A);
        check_ram();
        do_cmd(1'b0, 1'b0, 8'h06);

        // second write lands while busy and is dropped
        issue(1'b1, 1'b0, 8'h11, 1'b0, el);
        issue(1'b1, 1'b0, 8'h22, 1'b1, el);
        wait_idle();
        chk("busy_len_drop", last_len, BUSY_CYC);
        check_state();

        // illegal DDRAM address and read transactions
        do_cmd(1'b0, 1'b0, 8'hA0);
        do_cmd(1'b1, 1'b1, 8'h55);
        do_cmd(1'b0, 1'b1, 8'h01);
        check_ram();

        for (int k = 0; k < 40; k++) begin
            rs = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 9) == 0);
            d  = 8'($urandom_range(1, 255));
            if (!rs && !rw && d == 8'h01) d = 8'h02;
            do_cmd(rs, rw, d);
        end
        check_ram();

        // reset in the middle of a clear
        issue(1'b0, 1'b0, 8'h01, 1'b0, el);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_abort_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        check_state();
        do_cmd(1'b1, 1'b0, 8'h33);
        check_ram();

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 SHALL provide parameter BUSY_CYC, default 40: busy clk cycles after a normal instruction or data write.
REQ-002 SHALL provide parameter CLR_CYC, default 1600: busy clk cycles after Clear Display; legal range CLR_CYC >= 33.
REQ-003 clk  in  1  system clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 lcd_rs, lcd_rw, lcd_e  in  1 each  LCD bus strobes from the LCD writer (asynchronous to clk).
REQ-005 lcd_d  in  8  LCD data bus.
REQ-006 rd_addr  in  5  display-RAM read index (0-15 line 1, 16-31 line 2); rd_data  out  8  character at rd_addr.
REQ-007 cursor  out  5  current address counter; disp_on, cursor_on  out  1  display-control state.
REQ-008 busy  out  1  instruction in progress; init_done  out  1  Function Set seen.
REQ-009 cmd_valid  out  1  one-cycle pulse per executed RS=0 instruction; cmd_code  out  8  that instruction byte.
REQ-010 wr_valid  out  1  one-cycle pulse per executed RS=1 data write.
REQ-011 err  out  1  one-cycle pulse on dropped or illegal transaction.

Function
REQ-012 lcd_rs/rw/e/d SHALL each pass a 2-flop synchronizer; bus fields SHALL be captured every cycle the synchronized E is 1.
REQ-013 A transaction SHALL be detected on the cycle where synchronized E = 0 and its previous value = 1, and SHALL use the fields captured during the last E-high cycle.
REQ-014 All effects of a transaction (RAM, cursor, flags, pulses, busy rise) SHALL register on the clk edge following detection.
REQ-015 Transactions with RW=1 SHALL NOT change state and SHALL pulse err.
REQ-016 Transactions detected while busy=1 SHALL be dropped and SHALL pulse err.
REQ-017 FSM states: IDLE, CLEAR (RAM fill), WAIT (busy countdown); busy = 1 in CLEAR and WAIT.
REQ-018 RS=1: ram[cursor] <= lcd_d; cursor +1 if id=1, else -1, modulo 32 (31->0, 0->31); go to WAIT for BUSY_CYC cycles.
REQ-019 0x01 Clear: cursor <= 0, id <= 1; CLEAR writes 0x20 to entries 0..31, one per cycle; then WAIT so total busy = CLR_CYC cycles.
REQ-020 0x02/0x03 Return Home: cursor <= 0; RAM unchanged.
REQ-021 0b000001_ID_S Entry Mode: id <= bit1; S ignored.
REQ-022 0b00001DCB Display Control: disp_on <= D, cursor_on <= C; B ignored.
REQ-023 0b0001_SC_RL_xx Shift: SC=0 moves cursor +1 (RL=1) or -1 (RL=0) modulo 32; SC=1 no state change.
REQ-024 0b001xxxxx Function Set: init_done <= 1.
REQ-025 0b1AAAAAAA Set DDRAM: A = 0x00-0x0F -> cursor = A; A = 0x40-0x4F -> cursor = 16 + A[3:0]; any other A -> cursor unchanged, err pulse (cmd_valid still pulses).
REQ-026 0b01xxxxxx Set CGRAM: accepted, no state change.
REQ-027 Every non-Clear executed instruction SHALL hold busy for exactly BUSY_CYC cycles, starting on the REQ-014 edge.
REQ-028 rd_data SHALL be registered: ram[rd_addr] appears one cycle after rd_addr is sampled; a same-cycle write returns the old value.
REQ-029 cmd_valid, wr_valid and err SHALL never be high longer than one cycle per transaction.

Reset
REQ-030 rst=1 SHALL asynchronously force all 32 RAM entries to 0x20 and set cursor=0, id=1, disp_on=0, cursor_on=0, init_done=0, busy=0, state=IDLE.
REQ-031 rst=1 SHALL asynchronously force cmd_valid, wr_valid, err, rd_data and cmd_code to 0 and clear synchronizer and capture flops.
REQ-032 rst asserted mid-CLEAR or mid-WAIT SHALL abort the operation; after release the block SHALL accept the first complete E pulse.

Verification
REQ-033 Writes 0x38, 0x0C, 0x06, 0x01, each spaced beyond busy -> init_done=1, disp_on=1, cursor_on=0, id=1; after 0x01, busy high exactly 1600 cycles, all rd_data = 0x20.
REQ-034 Set DDRAM 0x4F, then data 'A' (0x41), then 'B' -> ram[31]=0x41, ram[0]=0x42, cursor=1, two wr_valid pulses.
REQ-035 Entry Mode 0x04, Set DDRAM 0x00, data 0x5A -> ram[0]=0x5A, cursor=31.
REQ-036 Second data write 5 cycles after the first (BUSY_CYC=40) -> second dropped, err one pulse, RAM and cursor unchanged by it.
REQ-037 Set DDRAM 0x20 -> cmd_valid and err pulse, cursor unchanged; RW=1 pulse -> err only, no state change.
REQ-038 rst asserted 10 cycles into Clear -> busy=0, RAM all 0x20; next write after release executes normally.
